memory_playback_sequencer: RTL

MEMORY_PLAYBACK_SEQUENCER -- requirements
Module: memory_playback_sequencer

---
 rtl/playback_pkg.sv | 35 +++
 rtl/playback_beat_timer.sv | 61 ++++++
 rtl/memory_playback_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/playback_pkg.sv
// ============================================================================
// Module      : playback_pkg
// Description : Shared types and constants for the memory playback sequencer:
//               the FSM state encoding, note/duration field widths, the
//               end-of-song marker and the bit positions of each word field.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package playback_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REWIND = 3'd1,
      ST_FETCH  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_PLAY   = 3'd4,
      ST_GAP    = 3'd5
   } state_e;

   localparam int          NOTE_W     = 5;
   localparam int          DUR_W      = 3;
   localparam logic [7:0]  END_MARKER = 8'hFF;

   // Word layout: [7:3] note code, [2:0] duration code (beats - 1)
   localparam int          NOTE_MSB   = 7;
   localparam int          NOTE_LSB   = 3;
   localparam int          DUR_MSB    = 2;
   localparam int          DUR_LSB    = 0;
   localparam int          WORD_MSB   = 7;

endpackage

`default_nettype wire

// File: rtl/playback_beat_timer.sv
// ============================================================================
// Module      : playback_beat_timer
// Description : Tick/beat counter pair that times one note. A load restarts
//               the count for (beats_i + 1) beats of TICKS_PER_BEAT cycles;
//               counting advances only while en_i is high, so holding en_i
//               low freezes the note time without losing progress.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               load_i         - restart with duration code beats_i
//               en_i           - advance one tick this cycle
//               beats_i[2:0]   - duration code (beats - 1)
//               done_o         - high on the final counted cycle of the note
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module playback_beat_timer
   import playback_pkg::*;
#(
   parameter int TICKS_PER_BEAT = 25000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [DUR_W-1:0] beats_i,
   output logic             done_o
);

   localparam int                TICK_W    = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);

   logic [TICK_W-1:0] tick_q;
   logic [DUR_W-1:0]  beat_q;
   logic              tick_last;

   assign tick_last = (tick_q == TICK_LAST);

   // Beat counter counts down to zero so the final beat is detected without
   // comparing against the loaded code; done fires on the last enabled tick.
   assign done_o = en_i && tick_last && (beat_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_q <= '0;
         beat_q <= '0;
      end else if (load_i) begin
         tick_q <= '0;
         beat_q <= beats_i;
      end else if (en_i) begin
         if (tick_last) begin
            tick_q <= '0;
            beat_q <= beat_q - 1'b1;
         end else begin
            tick_q <= tick_q + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/memory_playback_sequencer.sv
// ============================================================================
// Module      : memory_playback_sequencer
// Description : Reads note words from a memory unit and plays them back as
//               note codes with per-note durations and an inter-note gap.
//               Supports pause, stop, ready timeout and an end-of-song marker.
//               Compile-time option: define PLAYBACK_LOOP_EN to restart the
//               song from its first word after the marker instead of idling.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               start, stop, pause  - playback control
//               mem_data_in         - word from memory
//               mem_output_ready    - mem_data_in valid
//               mem_read_en         - fetch-next-word pulse
//               mem_read_rst        - rewind-read-pointer pulse
//               note_out[4:0]       - current note code, 0 = silence
//               playing             - high in every state except IDLE
//               song_done           - end-of-song marker pulse
//               err                 - ready timeout pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_playback_sequencer
   import playback_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int TICKS_PER_BEAT = 25000000,
   parameter int GAP_TICKS      = 2500000,
   parameter int RDY_TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  pause,
   input  logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic                  mem_output_ready,
   output logic                  mem_read_en,
   output logic                  mem_read_rst,
   output logic [NOTE_W-1:0]     note_out,
   output logic                  playing,
   output logic                  song_done,
   output logic                  err
);

   localparam int                WAIT_W    = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RDY_TIMEOUT - 1);
   localparam int                GAP_W     = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);

   state_e              state_q, state_d;
   logic [NOTE_W-1:0]   note_q, note_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

   logic                mem_read_en_q, mem_read_en_d;
   logic                mem_read_rst_q, mem_read_rst_d;
   logic [NOTE_W-1:0]   note_out_q, note_out_d;
   logic                playing_q, playing_d;
   logic                song_done_q, song_done_d;
   logic                err_q, err_d;

   logic                tmr_load, tmr_en, tmr_done;
   logic                word_is_marker;

   assign word_is_marker = (mem_data_in[WORD_MSB:0] == END_MARKER);

   playback_beat_timer #(
      .TICKS_PER_BEAT (TICKS_PER_BEAT)
   ) u_beat_timer (
      .clk     (clk),
      .rst     (rst),
      .load_i  (tmr_load),
      .en_i    (tmr_en),
      .beats_i (mem_data_in[DUR_MSB:DUR_LSB]),
      .done_o  (tmr_done)
   );

   // Next-state and next-output logic. Outputs are derived from the next
   // state so every output is a flop aligned with the state it describes.
   always_comb begin
      state_d        = state_q;
      note_d         = note_q;
      wait_cnt_d     = wait_cnt_q;
      gap_cnt_d      = gap_cnt_q;
      tmr_load       = 1'b0;
      tmr_en         = 1'b0;
      mem_read_rst_d = 1'b0;
      song_done_d    = 1'b0;
      err_d          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d = ST_REWIND;
            end
         end

         ST_REWIND: begin
            state_d = ST_FETCH;
         end

         ST_FETCH: begin
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
         end

         ST_WAIT: begin
            if (mem_output_ready) begin
               note_d = mem_data_in[NOTE_MSB:NOTE_LSB];
               if (word_is_marker) begin
                  song_done_d = 1'b1;
`ifdef PLAYBACK_LOOP_EN
                  state_d     = ST_REWIND;
`else
                  state_d     = ST_IDLE;
`endif
               end else begin
                  tmr_load = 1'b1;
                  state_d  = ST_PLAY;
               end
            end else if (wait_cnt_q == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end

         ST_PLAY: begin
            tmr_en = !pause;
            if (tmr_done) begin
               if (GAP_TICKS == 0) begin
                  state_d = ST_FETCH;
               end else begin
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
               end
            end
         end

         ST_GAP: begin
            if (!pause) begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_d = ST_FETCH;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Stop overrides everything outside IDLE, including a coincident
      // marker or timeout, and rewinds the memory for the next start.
      if (stop && (state_q != ST_IDLE)) begin
         state_d        = ST_IDLE;
         mem_read_rst_d = 1'b1;
         song_done_d    = 1'b0;
         err_d          = 1'b0;
         tmr_load       = 1'b0;
      end

      if (state_d == ST_REWIND) begin
         mem_read_rst_d = 1'b1;
      end
      mem_read_en_d = (state_d == ST_FETCH);
      playing_d     = (state_d != ST_IDLE);
      note_out_d    = ((state_d == ST_PLAY) && !pause) ? note_d : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         note_q         <= '0;
         wait_cnt_q     <= '0;
         gap_cnt_q      <= '0;
         mem_read_en_q  <= 1'b0;
         mem_read_rst_q <= 1'b0;
         note_out_q     <= '0;
         playing_q      <= 1'b0;
         song_done_q    <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         note_q         <= note_d;
         wait_cnt_q     <= wait_cnt_d;
         gap_cnt_q      <= gap_cnt_d;
         mem_read_en_q  <= mem_read_en_d;
         mem_read_rst_q <= mem_read_rst_d;
         note_out_q     <= note_out_d;
         playing_q      <= playing_d;
         song_done_q    <= song_done_d;
         err_q          <= err_d;
      end
   end

   assign mem_read_en  = mem_read_en_q;
   assign mem_read_rst = mem_read_rst_q;
   assign note_out     = note_out_q;
   assign playing      = playing_q;
   assign song_done    = song_done_q;
   assign err          = err_q;

endmodule

`default_nettype wire
